// File: rtl/core_v1_pkg.sv
// Shared definitions for core_v1: datapath width, reset PC, major opcodes
// and the fetch-stage state encoding.
// FETCH_ALIGN_CHK_EN adds the S_FAULT state used by the misaligned-redirect check.
package core_v1_pkg;

  localparam int          CORE_XLEN     = 32;
  localparam logic [31:0] CORE_RESET_PC = 32'h0000_0000;
  localparam int          INSTR_W       = 32;

  // RV32I major opcodes, as decoded from instr[6:0]
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // Fetch FSM encoding; S_FAULT exists only when the alignment check is built in
  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
`ifdef FETCH_ALIGN_CHK_EN
    ,
    S_FAULT = 2'd3
`endif
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with wrap-bit pointers. Used both as the fetch
// instruction buffer and as the in-order PC-tag queue for outstanding reads.
// flush empties the FIFO and wins over push/pop in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer and storage update; storage is cleared on reset so outputs read 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage of core_v1: owns the PC, issues word reads to instruction
// memory under a credit limit, buffers returned words with their PCs and
// hands {instr, pc} to decode. Redirects flush the buffer and drop any reads
// still in flight (S_DRAIN) before fetching from the new target.
// Optional feature macro: FETCH_ALIGN_CHK_EN (misaligned redirect -> sticky
// fetch_fault, fetching stops until reset). Without it the low two bits of
// redirect_pc are ignored.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1; a valid source holds its payload stable until that edge, and
// valid never depends combinationally on ready.
module instr_fetch
  import core_v1_pkg::*;
#(
  parameter int              XLEN       = CORE_XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(CORE_RESET_PC),
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_opcode,
  output logic [2:0]      id_funct3,
  output logic            fetch_fault,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam int BW = INSTR_W + XLEN;

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   drop_load;
  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            accept;
  logic            credit_ok;
  logic            ibuf_push;
  logic            ibuf_pop;
  logic [BW-1:0]   ibuf_dout;
  logic [CW-1:0]   ibuf_count;
  logic            ibuf_empty;
  logic            ibuf_full;
  logic [XLEN-1:0] tag_head;
  logic [CW-1:0]   tag_count;
  logic            tag_empty;
  logic            tag_full;
  logic            unused_sink;

`ifdef FETCH_ALIGN_CHK_EN
  logic fault_q;

  assign target      = redirect_pc;
  assign misaligned  = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fetch_fault = fault_q;
  assign unused_sink = ^{tag_count, tag_full, ibuf_full};

  // Sticky fault flag; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (misaligned) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign target      = {redirect_pc[XLEN-1:2], 2'b00};
  assign misaligned  = 1'b0;
  assign fetch_fault = 1'b0;
  assign unused_sink = ^{tag_count, tag_full, ibuf_full, redirect_pc[1:0]};
`endif

  // In-flight reads plus buffered words may never exceed the buffer size,
  // which is what keeps the instruction buffer from overflowing.
  assign credit_ok      = (SW'(outstanding) + SW'(ibuf_count)) < SW'(FIFO_DEPTH);
  assign imem_req_valid = (state == S_RUN) && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // A response arriving in the redirect cycle is already accounted for
  assign drop_load = outstanding - CW'(imem_rsp_valid);

  // Only responses that belong to the current fetch stream enter the buffer
  assign ibuf_push = imem_rsp_valid && (state == S_RUN) && !redirect_valid && !tag_empty;
  assign ibuf_pop  = id_valid && id_ready && !redirect_valid;

  assign id_valid             = !ibuf_empty;
  assign {id_instr, id_pc}    = ibuf_dout;
  assign id_opcode            = id_instr[6:0];
  assign id_funct3            = id_instr[14:12];
  assign dbg_state            = state;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; redirect overrides the normal progression
  always_comb begin
    state_next = state;
    case (state)
      S_BOOT:  state_next = S_RUN;
      S_RUN:   state_next = S_RUN;
      S_DRAIN: begin
        if ((drop_cnt == '0) || (imem_rsp_valid && (drop_cnt == CW'(1)))) begin
          state_next = S_RUN;
        end
      end
      default: state_next = state;
    endcase
    if (redirect_valid) begin
      state_next = (drop_load != '0) ? S_DRAIN : S_RUN;
    end
`ifdef FETCH_ALIGN_CHK_EN
    if ((state == S_FAULT) || misaligned) begin
      state_next = S_FAULT;
    end
`endif
  end

  // PC: load redirect target, otherwise advance on each accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid && !misaligned) begin
      pc <= target;
    end else if (accept) begin
      pc <= pc + XLEN'(4);
    end
  end

  // Reads in flight: up on accept, down on every response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
    end
  end

  // Count of stale responses still to be discarded after a redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      drop_cnt <= drop_load;
    end else if ((state == S_DRAIN) && imem_rsp_valid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end

  fetch_fifo #(
    .WIDTH (BW),
    .DEPTH (FIFO_DEPTH)
  ) u_ibuf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (ibuf_push),
    .din   ({imem_rsp_data, tag_head}),
    .pop   (ibuf_pop),
    .dout  (ibuf_dout),
    .count (ibuf_count),
    .empty (ibuf_empty),
    .full  (ibuf_full)
  );

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_tagq (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (accept),
    .din   (pc),
    .pop   (ibuf_push),
    .dout  (tag_head),
    .count (tag_count),
    .empty (tag_empty),
    .full  (tag_full)
  );

endmodule
